// File: rtl/sleep_ctrl.sv
// Always-on LFOSC-domain power manager: turns CPU WFI stalls into HFOSC clock-off requests,
// wakes on interrupt or timer expiry, and releases the CPU once the oscillator reports ready.
module sleep_ctrl #(
  parameter int HOLDOFF       = 4,
  parameter int WAKE_TICKS    = 10000,
  parameter int READY_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wfi_req,
  input  logic       wake_irq,
  input  logic       timer_en,
  input  logic       osc_ready,
  output logic       clk_req,
  output logic       cpu_run,
  output logic [1:0] wake_cause,
  output logic       osc_fault
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int RW = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);
  localparam logic [RW-1:0] RDY_LAST  = RW'(READY_TIMEOUT - 1);
  localparam logic [15:0]   TICK_LAST = 16'(WAKE_TICKS - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'b00,
    ST_SLEEP  = 2'b01,
    ST_WAKE   = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      wfi_sync_q, wfi_sync_d;
  logic [1:0]      irq_sync_q, irq_sync_d;
  logic [1:0]      rdy_sync_q, rdy_sync_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [15:0]     sleep_cnt_q, sleep_cnt_d;
  logic [RW-1:0]   rdy_cnt_q, rdy_cnt_d;
  logic            armed_q, armed_d;
  logic            clk_req_q, clk_req_d;
  logic            cpu_run_q, cpu_run_d;
  logic [1:0]      wake_cause_q, wake_cause_d;
  logic            osc_fault_q, osc_fault_d;
  logic            wfi_s, irq_s, rdy_s;
  logic            hold_cond, expiry;

  assign wfi_s = wfi_sync_q[1];
  assign irq_s = irq_sync_q[1];
  assign rdy_s = rdy_sync_q[1];

  // State register, synchronizers, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_WAKE;
      wfi_sync_q   <= 2'b00;
      irq_sync_q   <= 2'b00;
      rdy_sync_q   <= 2'b00;
      hold_cnt_q   <= '0;
      sleep_cnt_q  <= 16'd0;
      rdy_cnt_q    <= '0;
      armed_q      <= 1'b0;
      clk_req_q    <= 1'b1;
      cpu_run_q    <= 1'b0;
      wake_cause_q <= 2'b00;
      osc_fault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wfi_sync_q   <= wfi_sync_d;
      irq_sync_q   <= irq_sync_d;
      rdy_sync_q   <= rdy_sync_d;
      hold_cnt_q   <= hold_cnt_d;
      sleep_cnt_q  <= sleep_cnt_d;
      rdy_cnt_q    <= rdy_cnt_d;
      armed_q      <= armed_d;
      clk_req_q    <= clk_req_d;
      cpu_run_q    <= cpu_run_d;
      wake_cause_q <= wake_cause_d;
      osc_fault_q  <= osc_fault_d;
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    wfi_sync_d   = {wfi_sync_q[0], wfi_req};
    irq_sync_d   = {irq_sync_q[0], wake_irq};
    rdy_sync_d   = {rdy_sync_q[0], osc_ready};
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    sleep_cnt_d  = sleep_cnt_q;
    rdy_cnt_d    = rdy_cnt_q;
    armed_d      = armed_q;
    wake_cause_d = wake_cause_q;
    osc_fault_d  = 1'b0;
    hold_cond    = wfi_s & armed_q & ~irq_s;
    expiry       = timer_en & (sleep_cnt_q == TICK_LAST);
    // Outputs follow the registered state, so they switch one edge after it
    clk_req_d    = (state_q != ST_SLEEP);
    cpu_run_d    = (state_q == ST_ACTIVE);

    case (state_q)
      ST_ACTIVE: begin
        if (!rdy_s) begin
          state_d     = ST_WAKE;
          osc_fault_d = 1'b1;
          rdy_cnt_d   = '0;
          hold_cnt_d  = '0;
          armed_d     = 1'b0;
        end else begin
          if (!wfi_s) begin
            armed_d = 1'b1;
          end else begin
            armed_d = armed_q;
          end
          if (hold_cond && (hold_cnt_q == HOLD_LAST)) begin
            state_d      = ST_SLEEP;
            sleep_cnt_d  = 16'd0;
            armed_d      = 1'b0;
            wake_cause_d = 2'b00;
            hold_cnt_d   = '0;
          end else if (hold_cond) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end else begin
            hold_cnt_d = '0;
          end
        end
      end
      ST_SLEEP: begin
        if (irq_s || expiry) begin
          state_d      = ST_WAKE;
          wake_cause_d = {expiry, irq_s};
          rdy_cnt_d    = '0;
        end else if (timer_en) begin
          sleep_cnt_d = sleep_cnt_q + 16'd1;
        end else begin
          sleep_cnt_d = sleep_cnt_q;
        end
      end
      ST_WAKE: begin
        if (rdy_s) begin
          state_d    = ST_ACTIVE;
          hold_cnt_d = '0;
        end else if (rdy_cnt_q == RDY_LAST) begin
          osc_fault_d = 1'b1;
          rdy_cnt_d   = '0;
        end else begin
          rdy_cnt_d = rdy_cnt_q + RW'(1);
        end
      end
      default: begin
        state_d   = ST_WAKE;
        rdy_cnt_d = '0;
      end
    endcase
  end

  assign clk_req    = clk_req_q;
  assign cpu_run    = cpu_run_q;
  assign wake_cause = wake_cause_q;
  assign osc_fault  = osc_fault_q;

endmodule

// File: tb/tb_sleep_ctrl.sv
// Scoreboard bench for sleep_ctrl: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_sleep_ctrl;

  localparam int HOLDOFF       = 4;
  localparam int WAKE_TICKS    = 10;
  localparam int READY_TIMEOUT = 8;
  localparam int S_CLK = 0;
  localparam int S_RUN = 1;
  localparam int S_WC  = 2;
  localparam int S_FLT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       wfi_req;
  logic       wake_irq;
  logic       timer_en;
  logic       osc_ready;
  logic       clk_req;
  logic       cpu_run;
  logic [1:0] wake_cause;
  logic       osc_fault;

  typedef struct {
    int cyc;
    int sig;
    int val;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   m_act;
  int   cyc    = 0;
  int   n_run  = 0;
  int   n_fail = 0;

  sleep_ctrl #(
    .HOLDOFF      (HOLDOFF),
    .WAKE_TICKS   (WAKE_TICKS),
    .READY_TIMEOUT(READY_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wfi_req   (wfi_req),
    .wake_irq  (wake_irq),
    .timer_en  (timer_en),
    .osc_ready (osc_ready),
    .clk_req   (clk_req),
    .cpu_run   (cpu_run),
    .wake_cause(wake_cause),
    .osc_fault (osc_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sig_name(input int s);
    case (s)
      S_CLK:   return "clk_req";
      S_RUN:   return "cpu_run";
      S_WC:    return "wake_cause";
      S_FLT:   return "osc_fault";
      default: return "unknown";
    endcase
  endfunction

  function automatic int actual(input int s);
    case (s)
      S_CLK:   return int'(clk_req);
      S_RUN:   return int'(cpu_run);
      S_WC:    return int'(wake_cause);
      S_FLT:   return int'(osc_fault);
      default: return -1;
    endcase
  endfunction

  // Insert keeping the queue ordered by cycle
  task automatic expect_at(input int c, input int s, input int v);
    exp_t e;
    int   i;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        m_e   = sb.pop_front();
        m_act = actual(m_e.sig);
        n_run = n_run + 1;
        if (m_e.cyc != cyc || m_act != m_e.val) begin
          n_fail = n_fail + 1;
          $display("FAIL %s @cycle %0d (seen at %0d): got %0d, expected %0d",
                   sig_name(m_e.sig), m_e.cyc, cyc, m_act, m_e.val);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    wfi_req   = 1'b1;
    wake_irq  = 1'b0;
    timer_en  = 1'b1;
    osc_ready = 1'b0;
    expect_at(3, S_CLK, 1);
    expect_at(3, S_RUN, 0);
    expect_at(3, S_WC, 0);
    expect_at(3, S_FLT, 0);

    wait_cyc(3);
    n_run = n_run + 1;
    if (clk_req !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL direct clk_req during reset: got %0b, expected 1", clk_req);
    end
    n_run = n_run + 1;
    if (cpu_run !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL direct cpu_run during reset: got %0b, expected 0", cpu_run);
    end
    rst = 1'b0;

    // Release after reset: ready sampled at 8, cpu_run at 11
    wait_cyc(7);
    osc_ready = 1'b1;
    expect_at(10, S_RUN, 0);
    expect_at(10, S_FLT, 0);
    expect_at(11, S_RUN, 1);
    expect_at(11, S_WC, 0);
    expect_at(20, S_CLK, 1);

    // Fresh WFI edge: re-assert sampled at 23, clk_req falls at 29
    wait_cyc(21);
    n_run = n_run + 1;
    if (cpu_run !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL direct cpu_run at cycle 21: got %0b, expected 1", cpu_run);
    end
    n_run = n_run + 1;
    if (clk_req !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL direct clk_req at cycle 21: got %0b, expected 1", clk_req);
    end
    wfi_req = 1'b0;
    expect_at(28, S_CLK, 1);
    expect_at(29, S_CLK, 0);
    expect_at(29, S_RUN, 0);
    wait_cyc(22);
    wfi_req = 1'b1;
    // Timed wake: SLEEP registered at 28, expiry at 38
    expect_at(37, S_WC, 0);
    expect_at(38, S_WC, 2);
    expect_at(38, S_CLK, 0);
    expect_at(39, S_CLK, 1);
    expect_at(39, S_RUN, 0);
    expect_at(40, S_RUN, 1);

    // Holdoff interrupted by an irq pulse in its last cycle
    wait_cyc(44);
    wfi_req = 1'b0;
    wait_cyc(45);
    wfi_req = 1'b1;
    wait_cyc(48);
    wake_irq = 1'b1;
    expect_at(52, S_CLK, 1);
    expect_at(55, S_CLK, 1);
    expect_at(56, S_CLK, 0);
    wait_cyc(49);
    wake_irq = 1'b0;

    // irq_s lands exactly on timer expiry (edge 65)
    wait_cyc(62);
    wake_irq = 1'b1;
    expect_at(64, S_WC, 0);
    expect_at(65, S_WC, 3);
    expect_at(65, S_CLK, 0);
    expect_at(66, S_CLK, 1);
    expect_at(67, S_RUN, 1);
    wait_cyc(65);
    wake_irq = 1'b0;

    // Oscillator loss in ACTIVE, then repeated ready timeouts in WAKE
    wait_cyc(70);
    osc_ready = 1'b0;
    expect_at(72, S_FLT, 0);
    expect_at(73, S_FLT, 1);
    expect_at(74, S_FLT, 0);
    expect_at(74, S_RUN, 0);
    expect_at(80, S_FLT, 0);
    expect_at(81, S_FLT, 1);
    expect_at(82, S_FLT, 0);
    expect_at(85, S_CLK, 1);
    expect_at(89, S_FLT, 1);
    expect_at(90, S_RUN, 0);
    expect_at(97, S_FLT, 1);

    wait_cyc(98);
    osc_ready = 1'b1;
    expect_at(98, S_FLT, 0);
    expect_at(101, S_RUN, 0);
    expect_at(101, S_FLT, 0);
    expect_at(102, S_RUN, 1);
    expect_at(102, S_WC, 3);

    // Sleep with the timer disabled, then reset while sleeping
    wait_cyc(104);
    wfi_req  = 1'b0;
    timer_en = 1'b0;
    wait_cyc(105);
    wfi_req = 1'b1;
    expect_at(110, S_WC, 3);
    expect_at(111, S_WC, 0);
    expect_at(111, S_CLK, 1);
    expect_at(112, S_CLK, 0);
    expect_at(125, S_CLK, 0);
    expect_at(125, S_RUN, 0);

    wait_cyc(126);
    rst = 1'b1;
    expect_at(127, S_CLK, 1);
    expect_at(127, S_RUN, 0);
    expect_at(127, S_WC, 0);
    expect_at(127, S_FLT, 0);
    wait_cyc(127);
    rst      = 1'b0;
    timer_en = 1'b1;
    expect_at(135, S_RUN, 1);
    expect_at(135, S_WC, 0);
    expect_at(140, S_CLK, 1);

    wait_cyc(142);
    n_run = n_run + 1;
    if (cpu_run !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL direct cpu_run at cycle 142: got %0b, expected 1", cpu_run);
    end
    n_run = n_run + 1;
    if (clk_req !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL direct clk_req at cycle 142: got %0b, expected 1", clk_req);
    end
    while (sb.size() > 0) begin
      m_e    = sb.pop_front();
      n_run  = n_run + 1;
      n_fail = n_fail + 1;
      $display("FAIL %s @cycle %0d: never checked, expected %0d",
               sig_name(m_e.sig), m_e.cyc, m_e.val);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
